ahb_ext_cmd_sequencer: RTL and testbench



---
 rtl/ahb_ext_cmd_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_ahb_ext_cmd_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_ext_cmd_sequencer.sv
// Host command queue and single-outstanding-transfer sequencer for the AHB master ext_* port.
// Latency: a command accepted into an empty queue drives ext_enable on the next clock edge.
// Backpressure: cmd_ready drops while the queue is full or in reset; ext_* hold steady while a transfer is active.

// Generic synchronous FIFO with an occupancy count and a combinational head.
// Latency: a pushed entry is visible at the head one clock after the push.
// Backpressure: push_rdy is low when full or in reset; a same-cycle pop never frees a slot for a push.
module ahb_ext_cmd_sequencer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign push_rdy = !rst && (level != CNT_W'(DEPTH));
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop && (level != '0);
    assign head_dat = mem[rd_ptr];

    // Storage write; contents need no reset because level gates every use of the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + CNT_W'(1);
                2'b01:   level <= level - CNT_W'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

module ahb_ext_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic             hclk,
    input  logic             hreset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    input  logic             cmd_wr,
    input  logic [1:0]       cmd_slv_sel,
    output logic [31:0]      ext_addr,
    output logic [1:0]       ext_slv_sel_in,
    output logic [31:0]      ext_mast_din,
    output logic             ext_wr,
    output logic             ext_enable,
    output logic             ext_hbusreq_in,
    input  logic [31:0]      ext_mast_dout,
    input  logic             xfer_done,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_level
);
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic [1:0]  slv_sel;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    // Counter is one bit wider than strictly needed so it can never wrap before the abort.
    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    cmd_t          push_cmd;
    cmd_t          head_cmd;
    logic          fifo_pop;
    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] to_cnt;
    logic [TW-1:0] to_cnt_nxt;
    logic [31:0]   addr_nxt;
    logic [31:0]   din_nxt;
    logic [1:0]    slv_nxt;
    logic          wr_nxt;
    logic          enable_nxt;
    logic          rsp_valid_nxt;
    logic [31:0]   rsp_rdata_nxt;
    logic          rsp_err_nxt;

    assign push_cmd = '{addr: cmd_addr, wdata: cmd_wdata, wr: cmd_wr, slv_sel: cmd_slv_sel};

    ahb_ext_cmd_sequencer_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_cmd_fifo (
        .clk      (hclk),
        .rst      (hreset),
        .push_vld (cmd_valid),
        .push_rdy (cmd_ready),
        .push_dat (push_cmd),
        .pop      (fifo_pop),
        .head_dat (head_cmd),
        .level    (fifo_level)
    );

    // Bus request and enable are always asserted together.
    assign ext_hbusreq_in = ext_enable;
    assign busy           = (state != IDLE);

    // Next-state and next-output decode; holding values is the default in every state.
    always_comb begin
        state_nxt     = state;
        to_cnt_nxt    = to_cnt;
        addr_nxt      = ext_addr;
        din_nxt       = ext_mast_din;
        slv_nxt       = ext_slv_sel_in;
        wr_nxt        = ext_wr;
        enable_nxt    = ext_enable;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        fifo_pop      = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    fifo_pop   = 1'b1;
                    addr_nxt   = head_cmd.addr;
                    din_nxt    = head_cmd.wr ? head_cmd.wdata : 32'h0;
                    slv_nxt    = head_cmd.slv_sel;
                    wr_nxt     = head_cmd.wr;
                    enable_nxt = 1'b1;
                    to_cnt_nxt = '0;
                    state_nxt  = ACTIVE;
                end else begin
                    enable_nxt = 1'b0;
                end
            end
            ACTIVE: begin
                // Completion takes priority over a timeout landing on the same cycle.
                if (xfer_done) begin
                    enable_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = ext_wr ? 32'h0 : ext_mast_dout;
                    state_nxt     = GAP;
                end else if (to_cnt == TO_LAST) begin
                    enable_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = 32'h0;
                    state_nxt     = GAP;
                end else begin
                    to_cnt_nxt = to_cnt + TW'(1);
                end
            end
            GAP: begin
                enable_nxt = 1'b0;
                state_nxt  = IDLE;
            end
            default: begin
                enable_nxt = 1'b0;
                state_nxt  = IDLE;
            end
        endcase
    end

    // State, timeout counter and registered outputs; reset clears everything.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state          <= IDLE;
            to_cnt         <= '0;
            ext_addr       <= 32'h0;
            ext_mast_din   <= 32'h0;
            ext_slv_sel_in <= 2'b0;
            ext_wr         <= 1'b0;
            ext_enable     <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= 32'h0;
            rsp_err        <= 1'b0;
        end else begin
            state          <= state_nxt;
            to_cnt         <= to_cnt_nxt;
            ext_addr       <= addr_nxt;
            ext_mast_din   <= din_nxt;
            ext_slv_sel_in <= slv_nxt;
            ext_wr         <= wr_nxt;
            ext_enable     <= enable_nxt;
            rsp_valid      <= rsp_valid_nxt;
            rsp_rdata      <= rsp_rdata_nxt;
            rsp_err        <= rsp_err_nxt;
        end
    end
endmodule

// File: tb/tb_ahb_ext_cmd_sequencer.sv
// Directed bench for the ext_* command sequencer with a response scoreboard.
// Latency: a behavioural master answers xfer_done a programmable number of cycles after ext_enable rises.
// Backpressure: commands are held on cmd_valid until cmd_ready is seen.
module tb_ahb_ext_cmd_sequencer;
    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        cmd_wr = 1'b0;
    logic [1:0]  cmd_slv_sel = 2'b0;
    logic [31:0] ext_addr;
    logic [1:0]  ext_slv_sel_in;
    logic [31:0] ext_mast_din;
    logic        ext_wr;
    logic        ext_enable;
    logic        ext_hbusreq_in;
    logic [31:0] ext_mast_dout = 32'hBAD0_BAD0;
    logic        xfer_done = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [2:0]  fifo_level;

    int checks = 0;
    int failures = 0;
    int unstable = 0;
    int hi_run = 0;
    int lo_run = 0;
    int last_hi = 0;
    int min_lo = 1000;
    int done_after = 0;
    int hi_cnt = 0;
    bit prev_en = 1'b0;
    bit seen_hi = 1'b0;
    logic [66:0] snap = '0;
    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];

    ahb_ext_cmd_sequencer #(
        .FIFO_DEPTH (4),
        .CNT_W      (3),
        .TIMEOUT    (64)
    ) dut (
        .hclk           (hclk),
        .hreset         (hreset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .cmd_wr         (cmd_wr),
        .cmd_slv_sel    (cmd_slv_sel),
        .ext_addr       (ext_addr),
        .ext_slv_sel_in (ext_slv_sel_in),
        .ext_mast_din   (ext_mast_din),
        .ext_wr         (ext_wr),
        .ext_enable     (ext_enable),
        .ext_hbusreq_in (ext_hbusreq_in),
        .ext_mast_dout  (ext_mast_dout),
        .xfer_done      (xfer_done),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .busy           (busy),
        .fifo_level     (fifo_level)
    );

    always #5 hclk = ~hclk;

    // Read data the behavioural slave returns for an address.
    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return 32'h1234_5658 ^ a;
    endfunction

    // Behavioural master: pulses xfer_done done_after cycles into a transfer (0 = never).
    // Read data is only meaningful on the done cycle; a poison value is driven otherwise.
    always @(negedge hclk) begin
        if (hreset || !ext_enable) begin
            hi_cnt = 0;
            xfer_done = 1'b0;
            ext_mast_dout = 32'hBAD0_BAD0;
        end else if (xfer_done) begin
            xfer_done = 1'b0;
            ext_mast_dout = 32'hBAD0_BAD0;
        end else begin
            hi_cnt++;
            if (done_after > 0 && hi_cnt == done_after) begin
                xfer_done = 1'b1;
                ext_mast_dout = rd_of(ext_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample on the falling edge, collect responses and track enable activity.
    task automatic tick();
        @(negedge hclk);
        if (rsp_valid) obs_q.push_back({rsp_err, rsp_rdata});
        if (ext_hbusreq_in !== ext_enable) unstable++;
        if (ext_enable) begin
            if (prev_en && ({ext_addr, ext_mast_din, ext_wr, ext_slv_sel_in} !== snap)) unstable++;
            if (!prev_en && seen_hi && lo_run < min_lo) min_lo = lo_run;
            hi_run++;
            lo_run = 0;
            seen_hi = 1'b1;
        end else begin
            if (prev_en) last_hi = hi_run;
            hi_run = 0;
            lo_run++;
        end
        prev_en = ext_enable;
        snap = {ext_addr, ext_mast_din, ext_wr, ext_slv_sel_in};
    endtask

    // Present a command until accepted; cmd_valid is left high for back-to-back use.
    task automatic push(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] slv, input logic exp_err, input logic exp_rsp);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_wr = wr;
        cmd_addr = addr;
        cmd_wdata = wdata;
        cmd_slv_sel = slv;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            chk("push_stall", {63'b0, cmd_ready}, 64'd1);
        end else begin
            tick();
            if (exp_rsp) exp_q.push_back({exp_err, (wr || exp_err) ? 32'h0 : rd_of(addr)});
        end
    endtask

    // Wait for the next response and compare it against the scoreboard head.
    task automatic wait_rsp(input string tag, input int limit);
        int n = 0;
        logic [32:0] o;
        logic [32:0] e;
        while (obs_q.size() == 0 && n < limit) begin
            tick();
            n++;
        end
        if (obs_q.size() == 0) begin
            chk({tag, "_timeout"}, 64'(obs_q.size()), 64'd1);
        end else if (exp_q.size() == 0) begin
            chk({tag, "_unexpected"}, 64'(exp_q.size()), 64'd1);
            void'(obs_q.pop_front());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk(tag, 64'(o), 64'(e));
        end
    endtask

    initial begin
        // Reset behaviour
        repeat (3) tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_addr", 64'(ext_addr), 64'd0);
        chk("rst_din", 64'(ext_mast_din), 64'd0);
        chk("rst_ctl", 64'({ext_wr, ext_slv_sel_in, ext_enable, ext_hbusreq_in, rsp_valid, rsp_err, busy}), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        hreset = 1'b0;
        repeat (10) tick();
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("idle_level", 64'(fifo_level), 64'd0);
        chk("idle_ctl", 64'({ext_enable, ext_hbusreq_in, rsp_valid, busy}), 64'd0);

        // Single write, done three cycles after enable
        done_after = 3;
        push(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        chk("wr_en_after_accept", 64'(ext_enable), 64'd0);
        chk("wr_level_queued", 64'(fifo_level), 64'd1);
        tick();
        chk("wr_en", 64'(ext_enable), 64'd1);
        chk("wr_addr", 64'(ext_addr), 64'h10);
        chk("wr_din", 64'(ext_mast_din), 64'hDEAD_BEEF);
        chk("wr_wr", 64'(ext_wr), 64'd1);
        chk("wr_slv", 64'(ext_slv_sel_in), 64'd2);
        chk("wr_busy", 64'(busy), 64'd1);
        chk("wr_level_popped", 64'(fifo_level), 64'd0);
        wait_rsp("wr_rsp", 20);
        chk("wr_hi_len", 64'(last_hi), 64'd3);
        tick();
        chk("wr_rsp_one_cycle", 64'(rsp_valid), 64'd0);
        chk("wr_idle_busy", 64'(busy), 64'd0);

        // Single read
        push(1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 2'd1, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        tick();
        chk("rd_en", 64'(ext_enable), 64'd1);
        chk("rd_addr", 64'(ext_addr), 64'h20);
        chk("rd_din_zero", 64'(ext_mast_din), 64'd0);
        chk("rd_wr", 64'(ext_wr), 64'd0);
        wait_rsp("rd_rsp", 20);
        tick();
        chk("rd_rdata_hold", 64'(rsp_rdata), 64'h1234_5678);
        chk("rd_rsp_one_cycle", 64'(rsp_valid), 64'd0);
        repeat (3) tick();

        // Queue fill: six back-to-back commands against a slow master
        done_after = 20;
        min_lo = 1000;
        for (int i = 0; i < 6; i++) begin
            push(i[0], 32'h100 + 32'(i * 4), 32'hA5A5_0000 + 32'(i), 2'(i), 1'b0, 1'b1);
            if (i == 4) begin
                chk("q_full_level", 64'(fifo_level), 64'd4);
                chk("q_full_ready", 64'(cmd_ready), 64'd0);
            end
        end
        cmd_valid = 1'b0;
        chk("q_late_level", 64'(fifo_level), 64'd4);
        chk("q_late_after_pop", 64'(obs_q.size()), 64'd1);
        done_after = 3;
        for (int i = 0; i < 6; i++) wait_rsp("q_rsp", 200);
        chk("q_gap_low", 64'(min_lo), 64'd2);
        repeat (3) tick();

        // Timeout abort, then a normal command behind it
        done_after = 0;
        push(1'b0, 32'h0000_0040, 32'h0, 2'd3, 1'b1, 1'b1);
        push(1'b0, 32'h0000_0044, 32'h0, 2'd0, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        wait_rsp("to_rsp", 150);
        chk("to_hi_len", 64'(last_hi), 64'd64);
        done_after = 3;
        wait_rsp("to_next_rsp", 50);
        repeat (3) tick();

        // Completion landing on the timeout cycle
        done_after = 64;
        push(1'b0, 32'h0000_0080, 32'h0, 2'd1, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        wait_rsp("coinc_rsp", 150);
        chk("coinc_hi_len", 64'(last_hi), 64'd64);
        repeat (3) tick();

        // Reset during an active transfer with commands queued
        done_after = 0;
        for (int i = 0; i < 4; i++) push(1'b1, 32'h200 + 32'(i), 32'h5555_0000 + 32'(i), 2'd2, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        chk("mid_pre_en", 64'(ext_enable), 64'd1);
        chk("mid_pre_level", 64'(fifo_level), 64'd3);
        hreset = 1'b1;
        tick();
        chk("mid_en", 64'({ext_enable, ext_hbusreq_in}), 64'd0);
        chk("mid_level", 64'(fifo_level), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_ready", 64'(cmd_ready), 64'd0);
        chk("mid_addr", 64'(ext_addr), 64'd0);
        hreset = 1'b0;
        repeat (80) tick();
        chk("mid_no_rsp", 64'(obs_q.size()), 64'd0);
        chk("mid_idle", 64'({ext_enable, busy, fifo_level}), 64'd0);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        chk("ext_stable", 64'(unstable), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
